rs_stream_encoder: RTL and testbench

RS_STREAM_ENCODER -- requirements
Module: rs_stream_encoder

---
 rtl/rs_stream_encoder.sv | 164 ++++++++++++++++
 tb/tb_rs_stream_encoder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_stream_encoder.sv
// rs_stream_encoder
//   Streaming systematic Reed-Solomon (7,5) encoder over GF(8), primitive
//   polynomial x^3+x+1, generator g(x) = x^2 + a^4*x + a^3.
//   Five message symbols pass straight through to the output, followed by
//   the two parity symbols taken from a 2-stage division LFSR. A single
//   output register carries the stream and obeys valid/ready backpressure.
//   After the last parity symbol is loaded, the whole codeword is also
//   presented in packed form with a one-cycle cw_valid pulse.
//
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous, active-high
//   in_valid   : in_data holds a message symbol
//   in_data    : message symbol, highest degree first
//   in_ready   : message symbol accepted this cycle when in_valid is high
//   out_valid  : out_data holds a codeword symbol
//   out_data   : codeword symbol, degree 6 down to degree 0
//   out_last   : out_data is the degree-0 parity symbol
//   out_ready  : downstream takes out_data this cycle
//   cw_valid   : one-cycle pulse, codeword is complete
//   codeword   : packed codeword, x^i coefficient at bits [3i+2:3i]
//
// state | meaning
// ------+------------------------------------------------------------
// MSG   | accepting message symbols, counter tracks position 0..4
// PAR1  | waiting for a free output slot to emit the degree-1 parity
// PAR2  | waiting for a free output slot to emit the degree-0 parity

module rs_stream_encoder #(
  parameter int SYMBOL_WIDTH = 3,
  parameter int N            = 7,
  parameter int K            = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [SYMBOL_WIDTH-1:0]   in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [SYMBOL_WIDTH-1:0]   out_data,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic                      cw_valid,
  output logic [N*SYMBOL_WIDTH-1:0] codeword
);

  localparam logic [SYMBOL_WIDTH-1:0] G1      = 3'b110;
  localparam logic [SYMBOL_WIDTH-1:0] G0      = 3'b011;
  // low terms of the field polynomial, folded back in when x^3 overflows
  localparam logic [SYMBOL_WIDTH-1:0] POLY_LO = 3'b011;
  localparam logic [2:0]              CNT_MAX = 3'(K - 1);

  typedef enum logic [1:0] {
    MSG  = 2'd0,
    PAR1 = 2'd1,
    PAR2 = 2'd2
  } state_t;

  state_t                          r_state;
  logic [2:0]                      r_cnt;
  logic [SYMBOL_WIDTH-1:0]         r_r0;
  logic [SYMBOL_WIDTH-1:0]         r_r1;
  logic [K*SYMBOL_WIDTH-1:0]       r_shadow;

  logic                            w_slot_free;
  logic                            w_accept;
  logic [SYMBOL_WIDTH-1:0]         w_fb;
  logic [SYMBOL_WIDTH-1:0]         w_fb_g1;
  logic [SYMBOL_WIDTH-1:0]         w_fb_g0;

  // Shift-and-add multiply: walk b's bits, accumulating a*x^i.
  function automatic logic [SYMBOL_WIDTH-1:0] gf_mul(
    input logic [SYMBOL_WIDTH-1:0] a,
    input logic [SYMBOL_WIDTH-1:0] b
  );
    logic [SYMBOL_WIDTH-1:0] p;
    logic [SYMBOL_WIDTH-1:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < SYMBOL_WIDTH; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[SYMBOL_WIDTH-2:0], 1'b0} ^ (t[SYMBOL_WIDTH-1] ? POLY_LO : '0);
    end
    return p;
  endfunction

  // The output register can take a new symbol if it is empty or is being
  // drained in this same cycle.
  assign w_slot_free = !out_valid || out_ready;
  assign in_ready    = !reset && (r_state == MSG) && w_slot_free;
  assign w_accept    = in_valid && in_ready;

  assign w_fb    = in_data ^ r_r1;
  assign w_fb_g1 = gf_mul(w_fb, G1);
  assign w_fb_g0 = gf_mul(w_fb, G0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= MSG;
      r_cnt     <= '0;
      r_r0      <= '0;
      r_r1      <= '0;
      r_shadow  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      cw_valid  <= 1'b0;
      codeword  <= '0;
    end else begin
      cw_valid <= 1'b0;

      // Drained with nothing new to load: empty the slot. Any load below
      // overrides this.
      if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      case (r_state)
        MSG: begin
          if (w_accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            r_r1      <= r_r0 ^ w_fb_g1;
            r_r0      <= w_fb_g0;
            r_shadow  <= {r_shadow[(K-1)*SYMBOL_WIDTH-1:0], in_data};
            if (r_cnt == CNT_MAX) begin
              r_cnt   <= '0;
              r_state <= PAR1;
            end else begin
              r_cnt   <= r_cnt + 3'd1;
            end
          end
        end

        PAR1: begin
          if (w_slot_free) begin
            out_data  <= r_r1;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            r_state   <= PAR2;
          end
        end

        PAR2: begin
          if (w_slot_free) begin
            out_data  <= r_r0;
            out_valid <= 1'b1;
            out_last  <= 1'b1;
            codeword  <= {r_shadow, r_r1, r_r0};
            cw_valid  <= 1'b1;
            r_r0      <= '0;
            r_r1      <= '0;
            r_state   <= MSG;
          end
        end

        default: r_state <= MSG;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_stream_encoder.sv
// tb_rs_stream_encoder
//   Bench for rs_stream_encoder. A reference model computes each codeword by
//   polynomial long division over GF(8) (log/antilog tables) and queues the
//   expected output stream; one monitor checks every output transfer, the
//   backpressure hold rule, codeword pulses, syndromes and codeword hold.

module tb_rs_stream_encoder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [2:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [2:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic        cw_valid;
  logic [20:0] codeword;

  rs_stream_encoder #(.SYMBOL_WIDTH(3), .N(7), .K(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .cw_valid  (cw_valid),
    .codeword  (codeword)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- GF(8) reference arithmetic ----------------
  localparam logic [2:0] EXP_T [7] = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd6, 3'd7, 3'd5};
  localparam int         LOG_T [8] = '{0, 0, 1, 3, 2, 6, 4, 5};

  function automatic logic [2:0] gmul(input logic [2:0] a, input logic [2:0] b);
    if (a == 3'd0 || b == 3'd0) return 3'd0;
    return EXP_T[(LOG_T[a] + LOG_T[b]) % 7];
  endfunction

  // Systematic codeword: message at degrees 6..2, remainder of m(x)x^2 mod g(x)
  function automatic logic [20:0] gen_cw(input logic [2:0] m [5]);
    logic [2:0]  r [7];
    logic [2:0]  coef;
    logic [20:0] cw;
    for (int i = 0; i < 7; i++) r[i] = 3'd0;
    for (int i = 0; i < 5; i++) r[6-i] = m[i];
    for (int d = 6; d >= 2; d--) begin
      coef   = r[d];
      r[d]   = 3'd0;
      r[d-1] = r[d-1] ^ gmul(coef, 3'b110);
      r[d-2] = r[d-2] ^ gmul(coef, 3'b011);
    end
    cw = '0;
    for (int i = 0; i < 5; i++) cw[3*(6-i) +: 3] = m[i];
    cw[5:3] = r[1];
    cw[2:0] = r[0];
    return cw;
  endfunction

  function automatic logic [2:0] syndrome(input logic [20:0] cw, input int j);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < 7; i++) s = s ^ gmul(cw[3*i +: 3], EXP_T[(j * i) % 7]);
    return s;
  endfunction

  // ---------------- model queues ----------------
  typedef struct {
    logic [2:0] d;
    logic       l;
  } exp_t;

  exp_t        exp_sym [$];
  logic [20:0] exp_cw  [$];
  logic [2:0]  cur  [5];
  logic [2:0]  mbuf [5];
  int          nacc = 0;

  task automatic model_accept(input logic [2:0] s);
    exp_t        e;
    logic [20:0] cw;
    e.d = s;
    e.l = 1'b0;
    exp_sym.push_back(e);
    cur[nacc] = s;
    nacc++;
    if (nacc == 5) begin
      cw  = gen_cw(cur);
      e.d = cw[5:3]; e.l = 1'b0; exp_sym.push_back(e);
      e.d = cw[2:0]; e.l = 1'b1; exp_sym.push_back(e);
      exp_cw.push_back(cw);
      nacc = 0;
    end
  endtask

  task automatic model_flush();
    exp_sym.delete();
    exp_cw.delete();
    nacc = 0;
  endtask

  // ---------------- monitor ----------------
  logic        stall_prev = 1'b0;
  logic [2:0]  stall_d    = 3'd0;
  logic        stall_l    = 1'b0;
  logic [20:0] cw_hold    = '0;
  logic [20:0] last_cw    = '0;
  int          cw_count   = 0;

  always @(negedge clk) begin
    exp_t        e;
    logic [20:0] ec;
    if (reset) begin
      stall_prev = 1'b0;
      cw_hold    = '0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data",  32'(out_data),  32'(stall_d));
        check("hold_last",  32'(out_last),  32'(stall_l));
      end
      if (out_valid && out_ready) begin
        if (exp_sym.size() == 0) begin
          check("unexpected_symbol", 32'(out_data), 32'hFFFF);
        end else begin
          e = exp_sym.pop_front();
          check("out_data", 32'(out_data), 32'(e.d));
          check("out_last", 32'(out_last), 32'(e.l));
        end
      end
      if (cw_valid) begin
        check("cw_with_last", 32'(out_valid && out_last), 32'd1);
        if (exp_cw.size() == 0) begin
          check("unexpected_cw", 32'(codeword), 32'hFFFFFF);
        end else begin
          ec = exp_cw.pop_front();
          check("codeword", 32'(codeword), 32'(ec));
        end
        check("syndrome1", 32'(syndrome(codeword, 1)), 32'd0);
        check("syndrome2", 32'(syndrome(codeword, 2)), 32'd0);
        cw_hold = codeword;
        last_cw = codeword;
        cw_count++;
      end else begin
        check("cw_hold", 32'(codeword), 32'(cw_hold));
      end
      stall_prev = out_valid && !out_ready;
      stall_d    = out_data;
      stall_l    = out_last;
    end
  end

  // ---------------- drivers ----------------
  // Offers mbuf[0..n-1] in order; rnd randomises in_valid gaps and out_ready.
  task automatic send_msg(input int n, input bit rnd);
    int idx   = 0;
    int guard = 0;
    while (idx < n) begin
      @(posedge clk); #1;
      in_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data   = mbuf[idx];
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (in_valid && in_ready) begin
        model_accept(mbuf[idx]);
        idx++;
      end
      guard++;
      if (guard > 300) begin
        check("send_timeout", 32'(idx), 32'(n));
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    int guard = 0;
    while (exp_sym.size() != 0 || exp_cw.size() != 0) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      guard++;
      if (guard > 300) begin
        check("drain_timeout", 32'(exp_sym.size()), 32'd0);
        break;
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic directed(input logic [14:0] msg, input logic [20:0] want, input string nm);
    int c0;
    for (int i = 0; i < 5; i++) mbuf[i] = msg[3*(4-i) +: 3];
    c0 = cw_count;
    send_msg(5, 1'b0);
    drain(1'b0);
    check({nm, "_cw_count"}, 32'(cw_count), 32'(c0 + 1));
    check({nm, "_cw"},       32'(last_cw),  32'(want));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0] syms [10];
    int idx, cyc, lowcnt, xfers;
    bit started;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 3'd0;
    out_ready = 1'b0;

    // model pins
    mbuf = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
    check("model_00001", 32'(gen_cw(mbuf)), 32'h73);
    mbuf = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd0};
    check("model_00010", 32'(gen_cw(mbuf)), 32'h209);
    mbuf = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    check("model_zero",  32'(gen_cw(mbuf)), 32'h0);

    // reset state, with inputs trying to push data
    repeat (2) @(posedge clk);
    #1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_cw_valid",  32'(cw_valid),  32'd0);
    check("rst_codeword",  32'(codeword),  32'd0);
    @(posedge clk); #1;
    reset    = 1'b0;
    in_valid = 1'b0;

    directed(15'o00000, 21'h000000, "zeros");
    directed(15'o00001, 21'h000073, "m00001");
    directed(15'o00010, 21'h000209, "m00010");

    // reset after three accepted symbols
    mbuf = '{3'd5, 3'd6, 3'd7, 3'd1, 3'd2};
    send_msg(3, 1'b0);
    @(posedge clk); #1;
    reset    = 1'b1;
    in_valid = 1'b1;
    model_flush();
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    directed(15'o00010, 21'h000209, "after_rst");

    // two back-to-back codewords, out_ready held high
    syms = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3};
    idx = 0; cyc = 0; lowcnt = 0; xfers = 0; started = 1'b0;
    for (int t = 0; t < 60 && cyc < 15; t++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = (idx < 10);
      in_data   = (idx < 10) ? syms[idx] : 3'd0;
      @(negedge clk);
      if (!started && in_valid && in_ready) started = 1'b1;
      if (started) begin
        cyc++;
        if (cyc <= 14 && !in_ready) lowcnt++;
        if (cyc >= 2 && out_valid && out_ready) xfers++;
      end
      if (in_valid && in_ready) begin
        model_accept(syms[idx]);
        idx++;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_in_ready_low", 32'(lowcnt), 32'd4);
    check("b2b_transfers",    32'(xfers),  32'd14);
    drain(1'b0);

    // random messages, random gaps and backpressure
    for (int m = 0; m < 20; m++) begin
      for (int i = 0; i < 5; i++) mbuf[i] = 3'($urandom_range(0, 7));
      send_msg(5, 1'b1);
    end
    drain(1'b1);
    check("rand_all_cw", 32'(exp_cw.size()), 32'd0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
